// File: rtl/wb_write_buffer_if.sv
`default_nettype none
// ============================================================================
// Module      : wb_write_buffer_if
// Description : Retire-side request, register-file drain and bypass-lookup
//               signals of the write-back buffer.
// Revision    : 1.0 - initial release
// ============================================================================
interface wb_write_buffer_if #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32,
    parameter int REG_W = 5
);
    logic                       in_valid;
    logic                       in_ready;
    logic [REG_W-1:0]           in_reg;
    logic [XLEN-1:0]            in_data;
    logic                       wr_stall;
    logic                       wr_en;
    logic [REG_W-1:0]           wr_reg;
    logic [XLEN-1:0]            wr_data;
    logic [REG_W-1:0]           lookup_reg_1;
    logic [REG_W-1:0]           lookup_reg_2;
    logic                       hit_1;
    logic [XLEN-1:0]            hit_data_1;
    logic                       hit_2;
    logic [XLEN-1:0]            hit_data_2;
    logic [$clog2(DEPTH):0]     count;

    modport slave (
        input  in_valid, in_reg, in_data, wr_stall, lookup_reg_1, lookup_reg_2,
        output in_ready, wr_en, wr_reg, wr_data, hit_1, hit_data_1, hit_2,
               hit_data_2, count
    );

    modport master (
        output in_valid, in_reg, in_data, wr_stall, lookup_reg_1, lookup_reg_2,
        input  in_ready, wr_en, wr_reg, wr_data, hit_1, hit_data_1, hit_2,
               hit_data_2, count
    );
endinterface
`default_nettype wire

// File: rtl/wb_write_buffer.sv
`default_nettype none
// ============================================================================
// Module      : wb_write_buffer
// Description : In-order write-back FIFO in front of the register file write
//               port, with youngest-match bypass for two read indices.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_write_buffer #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32,
    parameter int REG_W = 5
) (
    input  wire logic           clk,
    input  wire logic           reset,
    wb_write_buffer_if.slave    bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);

    logic [REG_W-1:0] reg_q  [DEPTH];
    logic [XLEN-1:0]  data_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;

    logic             in_ready, empty, wr_en, push;
    logic [PTR_W-1:0] idx;
    logic             hit_1, hit_2;
    logic [XLEN-1:0]  hit_data_1, hit_data_2;

    always_comb begin
        in_ready   = !reset && (count_q < C_DEPTH);
        empty      = (count_q == '0);
        wr_en      = !reset && !empty && !bus.wr_stall;
        // x0 requests complete the handshake but are never stored.
        push       = bus.in_valid && in_ready && (bus.in_reg != '0);
        count_d    = count_q + CNT_W'(push) - CNT_W'(wr_en);
        hit_1      = 1'b0;
        hit_2      = 1'b0;
        hit_data_1 = '0;
        hit_data_2 = '0;
        idx        = '0;
        // Walk oldest to youngest so the last match seen is the youngest.
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr_q + PTR_W'(k);
            if (!reset && (CNT_W'(k) < count_q)) begin
                if ((bus.lookup_reg_1 != '0) && (reg_q[idx] == bus.lookup_reg_1)) begin
                    hit_1      = 1'b1;
                    hit_data_1 = data_q[idx];
                end
                if ((bus.lookup_reg_2 != '0) && (reg_q[idx] == bus.lookup_reg_2)) begin
                    hit_2      = 1'b1;
                    hit_data_2 = data_q[idx];
                end
            end
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.wr_en      = wr_en;
    assign bus.wr_reg     = (!reset && !empty) ? reg_q[rd_ptr_q]  : '0;
    assign bus.wr_data    = (!reset && !empty) ? data_q[rd_ptr_q] : '0;
    assign bus.hit_1      = hit_1;
    assign bus.hit_2      = hit_2;
    assign bus.hit_data_1 = hit_data_1;
    assign bus.hit_data_2 = hit_data_2;
    assign bus.count      = reset ? '0 : count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (wr_en) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
        end
    end

    // Entry storage carries no reset; occupancy alone defines validity.
    always_ff @(posedge clk) begin
        if (push) begin
            reg_q[wr_ptr_q]  <= bus.in_reg;
            data_q[wr_ptr_q] <= bus.in_data;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_wb_write_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_write_buffer
// Description : Directed and randomized self-checking bench for wb_write_buffer
//               with a downstream register file model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_write_buffer;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    wb_write_buffer_if #(.DEPTH(4), .XLEN(32), .REG_W(5)) bus ();

    wb_write_buffer #(.DEPTH(4), .XLEN(32), .REG_W(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Downstream register file: x0 is hard-wired to zero.
    logic [31:0] rf [32] = '{default: 32'h0};
    int          rf_wr_cnt = 0;
    always @(posedge clk) begin
        if (bus.wr_en) begin
            rf_wr_cnt <= rf_wr_cnt + 1;
            if (bus.wr_reg != 5'd0) rf[bus.wr_reg] <= bus.wr_data;
        end
    end

    typedef struct {
        logic [4:0]  r;
        logic [31:0] d;
    } ent_t;
    ent_t        q[$];
    logic [31:0] rf_ref [32];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic enq(input logic [4:0] r, input logic [31:0] d);
        bus.in_valid = 1'b1;
        bus.in_reg   = r;
        bus.in_data  = d;
        tick();
        bus.in_valid = 1'b0;
    endtask

    initial begin
        int          base;
        logic [31:0] exp_hd1, exp_hd2;
        logic        exp_h1, exp_h2, exp_ready, exp_wen;

        reset            = 1'b1;
        bus.in_valid     = 1'b1;
        bus.in_reg       = 5'd3;
        bus.in_data      = 32'h1234_5678;
        bus.wr_stall     = 1'b0;
        bus.lookup_reg_1 = 5'd3;
        bus.lookup_reg_2 = 5'd0;

        // Reset held two cycles with a pending request.
        tick();
        chk("rst_ready_c1", {31'b0, bus.in_ready}, 32'd0);
        chk("rst_wren_c1",  {31'b0, bus.wr_en},    32'd0);
        chk("rst_count_c1", {29'b0, bus.count},    32'd0);
        tick();
        chk("rst_ready_c2", {31'b0, bus.in_ready}, 32'd0);
        chk("rst_hit_c2",   {31'b0, bus.hit_1},    32'd0);
        chk("rst_wrreg_c2", {27'b0, bus.wr_reg},   32'd0);
        reset        = 1'b0;
        bus.in_valid = 1'b0;
        settle();
        chk("post_rst_ready", {31'b0, bus.in_ready}, 32'd1);
        chk("post_rst_count", {29'b0, bus.count},    32'd0);

        // Single write to x5.
        bus.in_valid     = 1'b1;
        bus.in_reg       = 5'd5;
        bus.in_data      = 32'hDEAD_BEEF;
        bus.lookup_reg_1 = 5'd5;
        settle();
        chk("single_not_visible", {31'b0, bus.hit_1}, 32'd0);
        tick();
        bus.in_valid = 1'b0;
        settle();
        chk("single_wren",   {31'b0, bus.wr_en},  32'd1);
        chk("single_wrreg",  {27'b0, bus.wr_reg}, 32'd5);
        chk("single_wrdata", bus.wr_data,         32'hDEAD_BEEF);
        chk("single_hit",    {31'b0, bus.hit_1},  32'd1);
        chk("single_hdata",  bus.hit_data_1,      32'hDEAD_BEEF);
        chk("single_count",  {29'b0, bus.count},  32'd1);
        tick();
        chk("single_count0", {29'b0, bus.count},  32'd0);
        chk("single_wren0",  {31'b0, bus.wr_en},  32'd0);
        chk("single_rf5",    rf[5],               32'hDEAD_BEEF);

        // Fill under stall, then drain in order.
        bus.wr_stall = 1'b1;
        for (int i = 1; i <= 4; i++) enq(5'(i), 32'(i));
        bus.in_valid = 1'b1;
        bus.in_reg   = 5'd9;
        bus.in_data  = 32'd99;
        settle();
        chk("fill_count",  {29'b0, bus.count},    32'd4);
        chk("fill_ready",  {31'b0, bus.in_ready}, 32'd0);
        chk("fill_wren",   {31'b0, bus.wr_en},    32'd0);
        tick();
        chk("fill_held",   {29'b0, bus.count},    32'd4);
        bus.wr_stall = 1'b0;
        settle();
        chk("drain_wrreg1",  {27'b0, bus.wr_reg},   32'd1);
        chk("drain_noready", {31'b0, bus.in_ready}, 32'd0);
        tick();
        chk("drain_wrreg2",  {27'b0, bus.wr_reg},   32'd2);
        chk("drain_ready",   {31'b0, bus.in_ready}, 32'd1);
        chk("drain_count3",  {29'b0, bus.count},    32'd3);
        tick();
        bus.in_valid = 1'b0;
        settle();
        chk("drain_wrreg3",  {27'b0, bus.wr_reg},   32'd3);
        chk("drain_count_wr",{29'b0, bus.count},    32'd3);
        tick();
        chk("drain_wrreg4",  {27'b0, bus.wr_reg},   32'd4);
        tick();
        chk("drain_wrreg9",  {27'b0, bus.wr_reg},   32'd9);
        chk("drain_wrdata9", bus.wr_data,           32'd99);
        tick();
        chk("drain_empty",   {29'b0, bus.count},    32'd0);
        for (int i = 1; i <= 4; i++) chk($sformatf("drain_rf%0d", i), rf[i], 32'(i));
        chk("drain_rf9", rf[9], 32'd99);

        // Youngest-match bypass.
        bus.wr_stall = 1'b1;
        enq(5'd7, 32'hA);
        enq(5'd7, 32'hB);
        bus.lookup_reg_1 = 5'd7;
        bus.lookup_reg_2 = 5'd3;
        settle();
        chk("young_hit",    {31'b0, bus.hit_1}, 32'd1);
        chk("young_hdata",  bus.hit_data_1,     32'hB);
        chk("young_miss2",  {31'b0, bus.hit_2}, 32'd0);
        chk("young_mdata2", bus.hit_data_2,     32'h0);
        bus.wr_stall = 1'b0;
        settle();
        chk("young_head", bus.wr_data, 32'hA);
        tick();
        chk("young_hdata_after", bus.hit_data_1, 32'hB);
        tick();
        chk("young_rf7", rf[7], 32'hB);

        // x0 filter.
        bus.lookup_reg_1 = 5'd0;
        bus.in_valid     = 1'b1;
        bus.in_reg       = 5'd0;
        bus.in_data      = 32'hFFFF_FFFF;
        settle();
        chk("x0_ready", {31'b0, bus.in_ready}, 32'd1);
        base = rf_wr_cnt;
        tick();
        bus.in_valid = 1'b0;
        settle();
        chk("x0_count", {29'b0, bus.count}, 32'd0);
        chk("x0_wren",  {31'b0, bus.wr_en}, 32'd0);
        chk("x0_hit",   {31'b0, bus.hit_1}, 32'd0);
        tick();
        chk("x0_nowrite", 32'(rf_wr_cnt - base), 32'd0);
        chk("x0_rf0", rf[0], 32'd0);

        // Reset with queued entries discards them.
        bus.wr_stall = 1'b1;
        enq(5'd10, 32'h100);
        enq(5'd11, 32'h101);
        enq(5'd12, 32'h102);
        bus.lookup_reg_1 = 5'd11;
        settle();
        chk("mid_count3", {29'b0, bus.count}, 32'd3);
        chk("mid_hit",    {31'b0, bus.hit_1}, 32'd1);
        reset = 1'b1;
        settle();
        chk("mid_rst_hit",   {31'b0, bus.hit_1},    32'd0);
        chk("mid_rst_ready", {31'b0, bus.in_ready}, 32'd0);
        tick();
        reset = 1'b0;
        settle();
        chk("mid_count0", {29'b0, bus.count}, 32'd0);
        chk("mid_hit0",   {31'b0, bus.hit_1}, 32'd0);
        base = rf_wr_cnt;
        bus.wr_stall = 1'b0;
        settle();
        chk("mid_wren0", {31'b0, bus.wr_en}, 32'd0);
        tick(); tick(); tick();
        chk("mid_nowrite", 32'(rf_wr_cnt - base), 32'd0);
        chk("mid_rf11",    rf[11], 32'd0);

        // Randomized traffic against a queue model.
        for (int i = 0; i < 32; i++) rf_ref[i] = rf[i];
        q.delete();
        for (int cyc = 0; cyc < 1000; cyc++) begin
            bus.in_valid     = ($urandom_range(0, 99) < 60);
            bus.in_reg       = 5'($urandom_range(0, 7));
            bus.in_data      = $urandom;
            bus.wr_stall     = ($urandom_range(0, 99) < 40);
            bus.lookup_reg_1 = 5'($urandom_range(0, 7));
            bus.lookup_reg_2 = 5'($urandom_range(0, 7));
            settle();
            exp_ready = (q.size() < 4);
            exp_wen   = (q.size() != 0) && !bus.wr_stall;
            exp_h1 = 1'b0; exp_hd1 = '0; exp_h2 = 1'b0; exp_hd2 = '0;
            foreach (q[j]) begin
                if (bus.lookup_reg_1 != 0 && q[j].r == bus.lookup_reg_1) begin
                    exp_h1 = 1'b1; exp_hd1 = q[j].d;
                end
                if (bus.lookup_reg_2 != 0 && q[j].r == bus.lookup_reg_2) begin
                    exp_h2 = 1'b1; exp_hd2 = q[j].d;
                end
            end
            chk("rnd_ready", {31'b0, bus.in_ready}, {31'b0, exp_ready});
            chk("rnd_wren",  {31'b0, bus.wr_en},    {31'b0, exp_wen});
            chk("rnd_count", {29'b0, bus.count},    32'(q.size()));
            chk("rnd_wrreg", {27'b0, bus.wr_reg},   (q.size() != 0) ? {27'b0, q[0].r} : 32'd0);
            chk("rnd_wrdata", bus.wr_data,          (q.size() != 0) ? q[0].d : 32'd0);
            chk("rnd_hit1",  {31'b0, bus.hit_1},    {31'b0, exp_h1});
            chk("rnd_hdata1", bus.hit_data_1,       exp_hd1);
            chk("rnd_hit2",  {31'b0, bus.hit_2},    {31'b0, exp_h2});
            chk("rnd_hdata2", bus.hit_data_2,       exp_hd2);
            if (exp_wen) begin
                if (q[0].r != 0) rf_ref[q[0].r] = q[0].d;
                void'(q.pop_front());
            end
            if (bus.in_valid && exp_ready && bus.in_reg != 0)
                q.push_back('{r: bus.in_reg, d: bus.in_data});
            tick();
        end
        bus.in_valid = 1'b0;
        bus.wr_stall = 1'b0;
        tick(); tick(); tick(); tick(); tick();
        chk("rnd_drained", {29'b0, bus.count}, 32'd0);
        while (q.size() != 0) begin
            rf_ref[q[0].r] = q[0].d;
            void'(q.pop_front());
        end
        for (int i = 0; i < 32; i++) chk($sformatf("rnd_rf%0d", i), rf[i], rf_ref[i]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
